// File: rtl/chacha_pkg.sv
// Shared types, default rotations, reference vectors and rotate helper
// for the byte-serial ChaCha quarter-round engine.
package chacha_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    localparam int unsigned DEF_ROT_A = 16;
    localparam int unsigned DEF_ROT_B = 12;
    localparam int unsigned DEF_ROT_C = 8;
    localparam int unsigned DEF_ROT_D = 7;

    // RFC 8439 quarter-round example, words a..d
    localparam logic [31:0] RFC_IN_A  = 32'h1111_1111;
    localparam logic [31:0] RFC_IN_B  = 32'h0102_0304;
    localparam logic [31:0] RFC_IN_C  = 32'h9b8d_6f43;
    localparam logic [31:0] RFC_IN_D  = 32'h0123_4567;
    localparam logic [31:0] RFC_OUT_A = 32'hea2a_92f4;
    localparam logic [31:0] RFC_OUT_B = 32'hcb1c_f8ce;
    localparam logic [31:0] RFC_OUT_C = 32'h4581_472e;
    localparam logic [31:0] RFC_OUT_D = 32'h5881_c4bb;

    // Rotate-left of the low w bits of x (w <= 64, r < w)
    function automatic logic [63:0] rotl(input logic [63:0] x,
                                         input int unsigned w,
                                         input int unsigned r);
        logic [63:0] m;
        logic [63:0] xm;
        m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        xm = x & m;
        return ((xm << r) | (xm >> (w - r))) & m;
    endfunction

endpackage

// File: rtl/chacha_qr_engine_if.sv
// Byte-wide input and output valid/ready streams of the quarter-round engine.
interface chacha_qr_engine_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
endinterface

// File: rtl/chacha_arx_step.sv
// One ARX step of a ChaCha quarter-round, selected by i_step (0..3).
module chacha_arx_step
    import chacha_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROT_A  = DEF_ROT_A,
    parameter int unsigned ROT_B  = DEF_ROT_B,
    parameter int unsigned ROT_C  = DEF_ROT_C,
    parameter int unsigned ROT_D  = DEF_ROT_D
) (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic [WORD_W-1:0] i_c,
    input  logic [WORD_W-1:0] i_d,
    input  logic [1:0]        i_step,
    output logic [WORD_W-1:0] o_a_c,
    output logic [WORD_W-1:0] o_b_c,
    output logic [WORD_W-1:0] o_c_c,
    output logic [WORD_W-1:0] o_d_c
);

    always_comb begin
        o_a_c = i_a;
        o_b_c = i_b;
        o_c_c = i_c;
        o_d_c = i_d;
        case (i_step)
            2'd0: begin
                o_a_c = i_a + i_b;
                o_d_c = WORD_W'(rotl(64'(i_d ^ o_a_c), WORD_W, ROT_A));
            end
            2'd1: begin
                o_c_c = i_c + i_d;
                o_b_c = WORD_W'(rotl(64'(i_b ^ o_c_c), WORD_W, ROT_B));
            end
            2'd2: begin
                o_a_c = i_a + i_b;
                o_d_c = WORD_W'(rotl(64'(i_d ^ o_a_c), WORD_W, ROT_C));
            end
            default: begin
                o_c_c = i_c + i_d;
                o_b_c = WORD_W'(rotl(64'(i_b ^ o_c_c), WORD_W, ROT_D));
            end
        endcase
    end

endmodule

// File: rtl/chacha_qr_engine.sv
// Byte-serial ChaCha quarter-round engine: load NB bytes, run ITERS
// quarter-rounds one ARX step per enabled cycle, then drain NB bytes.
module chacha_qr_engine
    import chacha_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ITERS  = 1,
    parameter int unsigned ROT_A  = DEF_ROT_A,
    parameter int unsigned ROT_B  = DEF_ROT_B,
    parameter int unsigned ROT_C  = DEF_ROT_C,
    parameter int unsigned ROT_D  = DEF_ROT_D
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    chacha_qr_engine_if.slave   bus,
    output logic                busy
);

    localparam int unsigned NB = 4 * WORD_W / 8;
    localparam int unsigned CW = $clog2(NB);
    localparam int unsigned IW = $clog2(ITERS) + 1;
    localparam int unsigned BW = 4 * WORD_W;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CW-1:0]     r_load_cnt;
    logic [CW-1:0]     r_drain_cnt;
    logic [1:0]        r_step;
    logic [IW-1:0]     r_iter;
    logic [BW-1:0]     r_blk;

    logic              w_in_take;
    logic              w_out_take;
    logic              w_load_last;
    logic              w_drain_last;
    logic              w_iter_last;
    logic [CW+2:0]     w_load_base;
    logic [CW+2:0]     w_drain_base;
    logic [WORD_W-1:0] w_a;
    logic [WORD_W-1:0] w_b;
    logic [WORD_W-1:0] w_c;
    logic [WORD_W-1:0] w_d;

    assign w_load_last  = (r_load_cnt == CW'(NB - 1));
    assign w_drain_last = (r_drain_cnt == CW'(NB - 1));
    assign w_iter_last  = (r_iter == IW'(ITERS - 1));
    assign w_load_base  = {r_load_cnt, 3'b000};
    assign w_drain_base = {r_drain_cnt, 3'b000};

    chacha_arx_step #(
        .WORD_W (WORD_W),
        .ROT_A  (ROT_A),
        .ROT_B  (ROT_B),
        .ROT_C  (ROT_C),
        .ROT_D  (ROT_D)
    ) u_arx (
        .i_a    (r_blk[0*WORD_W +: WORD_W]),
        .i_b    (r_blk[1*WORD_W +: WORD_W]),
        .i_c    (r_blk[2*WORD_W +: WORD_W]),
        .i_d    (r_blk[3*WORD_W +: WORD_W]),
        .i_step (r_step),
        .o_a_c  (w_a),
        .o_b_c  (w_b),
        .o_c_c  (w_c),
        .o_d_c  (w_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stream-side outputs decoded from the current state
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        busy          = 1'b0;
        w_in_take     = 1'b0;
        w_out_take    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                w_in_take    = bus.in_valid;
                if (w_in_take && w_load_last) w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                if (r_step == 2'd3 && w_iter_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_blk[w_drain_base +: 8];
                w_out_take    = bus.out_ready;
                if (w_out_take && w_drain_last) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
            r_step      <= '0;
            r_iter      <= '0;
            r_blk       <= '0;
        end else if (ena) begin
            if (w_in_take) begin
                r_blk[w_load_base +: 8] <= bus.in_data;
                r_load_cnt <= w_load_last ? '0 : r_load_cnt + 1'b1;
            end
            if (r_state == ST_COMPUTE) begin
                r_blk  <= {w_d, w_c, w_b, w_a};
                r_step <= r_step + 2'd1;
                if (r_step == 2'd3) r_iter <= w_iter_last ? '0 : r_iter + 1'b1;
            end
            if (w_out_take) begin
                r_drain_cnt <= w_drain_last ? '0 : r_drain_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chacha_qr_engine.sv
// Directed bench: RFC 8439 vector on the default engine, plus a 16-bit,
// 3-iteration engine checked against a quarter-round model.
module tb_chacha_qr_engine;
    import chacha_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic busy1;
    logic busy2;

    always #5 clk = ~clk;

    chacha_qr_engine_if bus1 ();
    chacha_qr_engine_if bus2 ();

    chacha_qr_engine u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus1),
        .busy  (busy1)
    );

    chacha_qr_engine #(
        .WORD_W (16),
        .ITERS  (3),
        .ROT_A  (8),
        .ROT_B  (12),
        .ROT_C  (4),
        .ROT_D  (7)
    ) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus2),
        .busy  (busy2)
    );

    // sel=0 drives the 32-bit engine, sel=1 the 16-bit engine
    logic       sel;
    logic       t_in_valid;
    logic [7:0] t_in_data;
    logic       t_out_ready;

    assign bus1.in_valid  = t_in_valid & ~sel;
    assign bus1.in_data   = t_in_data;
    assign bus1.out_ready = t_out_ready & ~sel;
    assign bus2.in_valid  = t_in_valid & sel;
    assign bus2.in_data   = t_in_data;
    assign bus2.out_ready = t_out_ready & sel;

    wire       w_in_ready  = sel ? bus2.in_ready  : bus1.in_ready;
    wire       w_out_valid = sel ? bus2.out_valid : bus1.out_valid;
    wire [7:0] w_out_data  = sel ? bus2.out_data  : bus1.out_data;
    wire       w_busy      = sel ? busy2          : busy1;

    int n_vec;
    int n_err;

    localparam logic [127:0] RFC_IN  = {RFC_IN_D, RFC_IN_C, RFC_IN_B, RFC_IN_A};
    localparam logic [127:0] RFC_OUT = {RFC_OUT_D, RFC_OUT_C, RFC_OUT_B, RFC_OUT_A};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rl16(input logic [15:0] x, input int r);
        logic [15:0] y;
        y = (x << r) | (x >> (16 - r));
        return y;
    endfunction

    function automatic logic [63:0] model16(input logic [63:0] blk);
        logic [15:0] a, b, c, d;
        a = blk[15:0]; b = blk[31:16]; c = blk[47:32]; d = blk[63:48];
        for (int k = 0; k < 3; k++) begin
            a = a + b; d = rl16(d ^ a, 8);
            c = c + d; b = rl16(b ^ c, 12);
            a = a + b; d = rl16(d ^ a, 4);
            c = c + d; b = rl16(b ^ c, 7);
        end
        return {d, c, b, a};
    endfunction

    task automatic send_blk(input logic [127:0] blk, input int nb);
        for (int i = 0; i < nb; i++) begin
            int guard;
            guard      = 0;
            t_in_valid = 1'b1;
            t_in_data  = blk[8*i +: 8];
            while (!w_in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            chk("send_in_ready", w_in_ready, 1);
            @(negedge clk);
        end
        t_in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!w_out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic recv_blk(output logic [127:0] blk, input int nb, input bit bp);
        blk = '0;
        for (int i = 0; i < nb; i++) begin
            int         guard;
            logic [7:0] held;
            guard = 0;
            while (!w_out_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            chk("recv_out_valid", w_out_valid, 1);
            chk("drain_in_ready_low", w_in_ready, 0);
            if (bp) begin
                t_out_ready = 1'b0;
                held = w_out_data;
                @(negedge clk);
                chk("bp_data_stable", w_out_data, held);
                chk("bp_valid_held", w_out_valid, 1);
            end
            t_out_ready   = 1'b1;
            blk[8*i +: 8] = w_out_data;
            @(negedge clk);
            t_out_ready = 1'b0;
        end
        chk("in_ready_after_drain", w_in_ready, 1);
    endtask

    initial begin
        logic [127:0] res;
        logic [63:0]  rblk;
        int           n;

        n_vec = 0; n_err = 0;
        sel = 1'b0; t_in_valid = 1'b0; t_in_data = 8'h00; t_out_ready = 1'b0;
        ena = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", w_in_ready, 1);
        chk("rst_out_valid", w_out_valid, 0);
        chk("rst_out_data", w_out_data, 0);
        chk("rst_busy", w_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // RFC vector, no backpressure
        send_blk(RFC_IN, 16);
        wait_out(n);
        chk("rfc_latency", n, 4);
        chk("rfc_first_byte", w_out_data, 8'hf4);
        recv_blk(res, 16, 1'b0);
        chk("rfc_result", res, RFC_OUT);

        // RFC vector with out_ready toggling
        send_blk(RFC_IN, 16);
        wait_out(n);
        chk("bp_latency", n, 4);
        recv_blk(res, 16, 1'b1);
        chk("bp_result", res, RFC_OUT);

        // ena dropped for 5 cycles at step 2
        send_blk(RFC_IN, 16);
        n = 0;
        repeat (2) begin @(negedge clk); n++; end
        ena = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n++;
            chk("stall_busy", w_busy, 1);
            chk("stall_out_valid", w_out_valid, 0);
        end
        ena = 1'b1;
        while (!w_out_valid && n < 200) begin @(negedge clk); n++; end
        chk("stall_latency", n, 9);
        recv_blk(res, 16, 1'b0);
        chk("stall_result", res, RFC_OUT);

        // reset during step 1
        send_blk(RFC_IN, 16);
        @(negedge clk);
        chk("pre_rst_busy", w_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", w_in_ready, 1);
        chk("midrst_out_valid", w_out_valid, 0);
        chk("midrst_busy", w_busy, 0);
        chk("midrst_out_data", w_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_blk(RFC_IN, 16);
        wait_out(n);
        chk("postrst_latency", n, 4);
        recv_blk(res, 16, 1'b0);
        chk("postrst_result", res, RFC_OUT);

        // in_valid held with 0xAA through COMPUTE and DRAIN
        send_blk(RFC_IN, 16);
        t_in_valid = 1'b1;
        t_in_data  = 8'hAA;
        wait_out(n);
        chk("ignore_latency", n, 4);
        recv_blk(res, 16, 1'b0);
        t_in_valid = 1'b0;
        chk("ignore_result", res, RFC_OUT);
        send_blk(RFC_IN, 16);
        wait_out(n);
        recv_blk(res, 16, 1'b0);
        chk("ignore_next_block", res, RFC_OUT);

        // 16-bit words, 3 iterations, random blocks
        sel = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            rblk = {$urandom(), $urandom()};
            send_blk({64'd0, rblk}, 8);
            wait_out(n);
            chk("w16_latency", n, 12);
            recv_blk(res, 8, k[0]);
            chk("w16_result", res, {64'd0, model16(rblk)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
